// File: rtl/norm_shifter.sv
// norm_shifter: two-stage valid/ready pipeline that left-normalises a word
// by an upstream zero count. Define NORM_SHIFTER_CHECK_EN for the out_err checker.
module norm_shifter #(
  parameter int IN_W  = 8,
  parameter int CNT_W = $clog2(IN_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [CNT_W-1:0] in_zcnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IN_W-1:0]  out_data,
  output logic [CNT_W-1:0] out_shift,
`ifdef NORM_SHIFTER_CHECK_EN
  output logic             out_err,
`endif
  output logic             out_zero
);

  logic             s1_valid_q, s1_valid_d;
  logic [IN_W-1:0]  s1_data_q, s1_data_d;
  logic [CNT_W-1:0] s1_cnt_q, s1_cnt_d;
  logic             s2_valid_q, s2_valid_d;
  logic [IN_W-1:0]  s2_data_q, s2_data_d;
  logic [CNT_W-1:0] s2_cnt_q, s2_cnt_d;
  logic             s2_zero_q, s2_zero_d;

  logic             s2_load;
  logic             s1_adv;
  logic             in_xfer;
  logic [CNT_W-1:0] eff_cnt;
  logic [IN_W-1:0]  shifted;

  always_comb begin
    s2_load  = !s2_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_load;
    in_ready = !s1_valid_q || s2_load;
    in_xfer  = in_valid && in_ready;
    // counts past the word width saturate so the shift always clears it
    eff_cnt  = (in_zcnt > CNT_W'(IN_W)) ? CNT_W'(IN_W) : in_zcnt;
    shifted  = s1_data_q << s1_cnt_q;

    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_cnt_d   = s1_cnt_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_cnt_d   = s2_cnt_q;
    s2_zero_d  = s2_zero_q;

    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data;
      s1_cnt_d   = eff_cnt;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) s2_valid_d = s1_valid_q;
    if (s1_adv) begin
      s2_data_d = shifted;
      s2_cnt_d  = s1_cnt_q;
      s2_zero_d = (shifted == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_cnt_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_cnt_q   <= '0;
      s2_zero_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_cnt_q   <= s1_cnt_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_cnt_q   <= s2_cnt_d;
      s2_zero_q  <= s2_zero_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_shift = s2_cnt_q;
  assign out_zero  = s2_zero_q;

`ifdef NORM_SHIFTER_CHECK_EN
  logic             s1_err_q, s1_err_d;
  logic             s2_err_q, s2_err_d;
  logic [CNT_W-1:0] true_lzc;

  // raw in_zcnt is compared, so an oversized count is flagged too
  always_comb begin
    true_lzc = CNT_W'(IN_W);
    for (int i = 0; i < IN_W; i++) begin
      if (in_data[i]) true_lzc = CNT_W'(IN_W - 1 - i);
    end
    s1_err_d = s1_err_q;
    s2_err_d = s2_err_q;
    if (in_xfer) s1_err_d = (in_zcnt != true_lzc);
    if (s1_adv)  s2_err_d = s1_err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_err_q <= 1'b0;
      s2_err_q <= 1'b0;
    end else begin
      s1_err_q <= s1_err_d;
      s2_err_q <= s2_err_d;
    end
  end

  assign out_err = s2_err_q;
`endif

endmodule

// File: tb/tb_norm_shifter.sv
// tb_norm_shifter: randomized and directed checks of norm_shifter against
// a queue-based reference model (IN_W=8, CNT_W=4).
module tb_norm_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] in_zcnt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_shift;
  logic       out_zero;
  logic       out_err;

  always #5 clk = ~clk;

  norm_shifter #(.IN_W(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_zcnt   (in_zcnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shift (out_shift),
`ifdef NORM_SHIFTER_CHECK_EN
    .out_err   (out_err),
`endif
    .out_zero  (out_zero)
  );

`ifndef NORM_SHIFTER_CHECK_EN
  assign out_err = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic [3:0] shift;
    logic       zero;
    logic       err;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   checks;
  int   passed;

  function automatic exp_t ref_model(logic [7:0] d, logic [3:0] z);
    exp_t r;
    int   eff;
    int   v;
    int   lz;
    bit   seen;
    eff = (int'(z) > 8) ? 8 : int'(z);
    v   = (int'(d) * (1 << eff)) % 256;
    lz  = 0;
    seen = 0;
    for (int b = 7; b >= 0; b--) begin
      if (d[b]) seen = 1;
      if (!seen) lz++;
    end
    r.data  = v[7:0];
    r.shift = eff[3:0];
    r.zero  = (v == 0);
    r.err   = (lz != int'(z));
    r.acc   = 0;
    return r;
  endfunction

  // one clock cycle: drive, check against the model, advance the model
  task automatic cycle(input bit iv, input logic [7:0] d,
                       input logic [3:0] z, input bit ordy,
                       output bit accepted);
    exp_t e;
    bit   exp_ir;
    bit   exp_ov;
    in_valid  = iv;
    in_data   = d;
    in_zcnt   = z;
    out_ready = ordy;
    #2;
    exp_ir = (q.size() < 2) || ordy;
    exp_ov = (q.size() > 0) && (cyc >= q[0].acc + 2);
    checks++;
    if (in_ready !== exp_ir)
      $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ir);
    else passed++;
    checks++;
    if (out_valid !== exp_ov)
      $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_ov);
    else passed++;
    if (exp_ov) begin
      e = q[0];
      checks++;
      if (out_data !== e.data || out_shift !== e.shift || out_zero !== e.zero)
        $display("FAIL out_fields cyc=%0d got=%h/%0d/%b exp=%h/%0d/%b",
                 cyc, out_data, out_shift, out_zero, e.data, e.shift, e.zero);
      else passed++;
`ifdef NORM_SHIFTER_CHECK_EN
      checks++;
      if (out_err !== e.err)
        $display("FAIL out_err cyc=%0d got=%b exp=%b", cyc, out_err, e.err);
      else passed++;
`endif
    end
    accepted = iv && exp_ir;
    if (exp_ov && ordy) void'(q.pop_front());
    if (accepted) begin
      e = ref_model(d, z);
      e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    in_zcnt   = 4'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 ||
        out_shift !== 4'd0 || out_zero !== 1'b0)
      $display("FAIL reset_outputs got=%b/%h/%0d/%b exp=0/00/0/0",
               out_valid, out_data, out_shift, out_zero);
    else passed++;
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1)
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    else passed++;
    q.delete();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_directed();
    bit a;
    cycle(1, 8'b0001_0110, 4'd3, 1, a);
    cycle(1, 8'h00, 4'd8, 1, a);
    cycle(1, 8'h00, 4'd12, 1, a);
    cycle(1, 8'h40, 4'd2, 1, a);
    cycle(1, 8'h40, 4'd1, 1, a);
    cycle(1, 8'h80, 4'd15, 1, a);
    repeat (4) cycle(0, 8'hFF, 4'hF, 1, a);
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [4];
    int idx;
    bit a;
    for (int i = 0; i < 4; i++) w[i] = 8'($urandom_range(1, 255));
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      cycle(idx < 4, w[idx % 4], 4'(c), 0, a);
      if (a) idx++;
    end
    checks++;
    if (idx !== 2)
      $display("FAIL stall_accepts got=%0d exp=2", idx);
    else passed++;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      cycle(1, w[idx], 4'(idx), 1, a);
      if (a) idx++;
    end
    checks++;
    if (idx !== 4)
      $display("FAIL release_accepts got=%0d exp=4", idx);
    else passed++;
    repeat (4) cycle(0, 8'h00, 4'd0, 1, a);
  endtask

  task automatic test_random();
    bit a;
    logic [7:0] d;
    logic [3:0] z;
    for (int n = 0; n < 400; n++) begin
      d = 8'($urandom_range(0, 255) >> $urandom_range(0, 8));
      z = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        z = 4'd8;
        for (int b = 0; b < 8; b++) if (d[b]) z = 4'(7 - b);
      end
      cycle($urandom_range(0, 3) != 0, d, z, $urandom_range(0, 2) != 0, a);
    end
    repeat (4) cycle(0, 8'h00, 4'd0, 1, a);
  endtask

  task automatic test_mid_reset();
    bit a;
    cycle(1, 8'h11, 4'd3, 0, a);
    cycle(1, 8'h22, 4'd2, 0, a);
    cycle(0, 8'h00, 4'd0, 0, a);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL mid_reset got=%b/%b exp=0/1", out_valid, in_ready);
    else passed++;
    q.delete();
    @(posedge clk);
    cyc++;
    #1;
    repeat (5) cycle(0, 8'hFF, 4'd0, 1, a);
    cycle(1, 8'h03, 4'd6, 1, a);
    repeat (3) cycle(0, 8'h00, 4'd0, 1, a);
  endtask

  initial begin
    checks    = 0;
    passed    = 0;
    cyc       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_zcnt   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
